trdb_priority: RTL and testbench

Combinational packet-priority arbiter of the trace encoder (RISC-V E-Trace style). Each cycle it takes the last-cycle (lc_), this-cycle (tc_) and next-cycle (nc_) instruction-event flags from the encoder pipeline. It decides whether a packet is emitted and, if so, which format and subformat. It also drives the mux selects and resync-timer reset consumed by the packet emitter downstream.

---
 rtl/trdb_pkg.sv | 35 +++
 rtl/trdb_priority.sv | 165 ++++++++++++++++
 tb/tb_trdb_priority.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/trdb_pkg.sv
// trdb_pkg: shared types for the trace-encoder packet logic.
//   format_e           - packet format (opt/ext, branch+diff, addr-only, sync)
//   f_sync_subformat_e - subformat of a sync packet
//   qual_status_e      - qualification status reported in support packets
//   branch_format()    - picks addr-only vs branch+diff from branch map state
package trdb_pkg;

    typedef enum logic [1:0] {
        F_OPT_EXT    = 2'd0,
        F_DIFF_DELTA = 2'd1,
        F_ADDR_ONLY  = 2'd2,
        F_SYNC       = 2'd3
    } format_e;

    typedef enum logic [1:0] {
        SF_START   = 2'd0,
        SF_TRAP    = 2'd1,
        SF_CONTEXT = 2'd2,
        SF_SUPPORT = 2'd3
    } f_sync_subformat_e;

    typedef enum logic [1:0] {
        NO_CHANGE  = 2'd0,
        ENDED_REP  = 2'd1,
        TRACE_LOST = 2'd2,
        ENDED_NTR  = 2'd3
    } qual_status_e;

    // With no branches pending there is nothing for a branch map to carry,
    // so an address-only packet suffices.
    function automatic format_e branch_format(input logic map_empty);
        return map_empty ? F_ADDR_ONLY : F_DIFF_DELTA;
    endfunction

endpackage

// File: rtl/trdb_priority.sv
// trdb_priority: combinational packet-priority arbiter of the trace encoder.
// Decides per cycle whether a packet is emitted and with which format and
// subformat, plus the mux selects / resync-timer reset for the emitter.
//
// Ports:
//   clk_i, rst_ni               clock (unused, no state) / async active-low reset
//   valid_i                     slot holds a valid instruction
//   lc_*                        last-cycle event flags
//   tc_*                        this-cycle event flags
//   nc_*                        next-cycle event flags
//   valid_o                     packet requested
//   packet_format_o             format_e
//   packet_f_sync_subformat_o   f_sync_subformat_e (0 unless format is sync)
//   thaddr_o                    trap-packet thaddr bit
//   cause_mux_o, tval_mux_o     1 = last-cycle cause/tval
//   resync_timer_rst_o          clear resync counter
//   qual_status_o               qual_status_e
module trdb_priority
    import trdb_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       valid_i,
    input  logic       lc_exception_i,
    input  logic       lc_updiscon_i,
    input  logic       lc_final_qualified_i,
    input  logic       tc_qualified_i,
    input  logic       tc_retired_i,
    input  logic       tc_exception_i,
    input  logic       tc_first_qualified_i,
    input  logic       tc_privchange_i,
    input  logic       tc_context_change_i,
    input  logic       tc_gt_max_resync_i,
    input  logic       tc_et_max_resync_i,
    input  logic       tc_branch_map_empty_i,
    input  logic       tc_branch_map_full_i,
    input  logic       tc_enc_enabled_i,
    input  logic       tc_enc_disabled_i,
    input  logic       tc_opmode_change_i,
    input  logic       nc_exception_i,
    input  logic       nc_privchange_i,
    input  logic       nc_context_change_i,
    input  logic       nc_branch_map_empty_i,
    input  logic       nc_qualified_i,
    input  logic       nc_retired_i,
    output logic       valid_o,
    output logic [1:0] packet_format_o,
    output logic [1:0] packet_f_sync_subformat_o,
    output logic       thaddr_o,
    output logic       cause_mux_o,
    output logic       tval_mux_o,
    output logic       resync_timer_rst_o,
    output logic [1:0] qual_status_o
);

    format_e           format;
    f_sync_subformat_e subformat;
    qual_status_e      qual_status;
    logic              valid;
    logic              thaddr;
    logic              cause_mux;
    logic              tval_mux;
    logic              resync_rst;

    // Inputs with no effect on the decision; kept on the port list so the
    // block stays pin-compatible with the encoder pipeline.
    logic unused_inputs;
    assign unused_inputs = clk_i ^ tc_exception_i ^ nc_branch_map_empty_i;

    logic encoder_ctrl;
    logic qual_ended;
    logic qual_ret;
    logic start_needed;
    logic resync_overdue;
    logic nc_boundary;

    always_comb begin
        encoder_ctrl   = tc_enc_enabled_i | tc_enc_disabled_i | tc_opmode_change_i;
        qual_ended     = !tc_qualified_i && lc_final_qualified_i;
        qual_ret       = tc_qualified_i && tc_retired_i;
        start_needed   = tc_first_qualified_i | tc_privchange_i | tc_context_change_i |
                         (tc_et_max_resync_i & tc_branch_map_empty_i);
        resync_overdue = tc_gt_max_resync_i & !tc_branch_map_empty_i;
        // Next instruction is a trace boundary: flush what we have now.
        nc_boundary    = nc_exception_i | nc_privchange_i | nc_context_change_i |
                         !nc_qualified_i | !nc_retired_i;
    end

    always_comb begin
        valid       = 1'b0;
        format      = F_OPT_EXT;
        subformat   = SF_START;
        qual_status = NO_CHANGE;
        thaddr      = 1'b0;
        cause_mux   = 1'b0;
        tval_mux    = 1'b0;
        resync_rst  = 1'b0;

        if (valid_i) begin
            if (encoder_ctrl) begin
                valid       = 1'b1;
                format      = F_SYNC;
                subformat   = SF_SUPPORT;
                qual_status = tc_enc_disabled_i ? ENDED_NTR : NO_CHANGE;
            end else if (qual_ended) begin
                valid       = 1'b1;
                format      = F_SYNC;
                subformat   = SF_SUPPORT;
                qual_status = ENDED_REP;
            end else if (qual_ret) begin
                if (lc_exception_i) begin
                    valid      = 1'b1;
                    format     = F_SYNC;
                    subformat  = SF_TRAP;
                    cause_mux  = 1'b1;
                    tval_mux   = 1'b1;
                    // thaddr=0 signals the trap followed an uninferable jump
                    thaddr     = !lc_updiscon_i;
                    resync_rst = 1'b1;
                end else if (start_needed) begin
                    valid      = 1'b1;
                    format     = F_SYNC;
                    subformat  = SF_START;
                    resync_rst = 1'b1;
                end else if (lc_updiscon_i) begin
                    valid  = 1'b1;
                    format = branch_format(tc_branch_map_empty_i);
                end else if (resync_overdue) begin
                    valid      = 1'b1;
                    format     = F_DIFF_DELTA;
                    resync_rst = 1'b1;
                end else if (nc_boundary) begin
                    valid  = 1'b1;
                    format = branch_format(tc_branch_map_empty_i);
                end else if (tc_branch_map_full_i) begin
                    valid  = 1'b1;
                    format = F_DIFF_DELTA;
                end
            end
        end
    end

    // Reset gates the combinational result directly, so it acts without a clock.
    always_comb begin
        valid_o                   = '0;
        packet_format_o           = '0;
        packet_f_sync_subformat_o = '0;
        thaddr_o                  = '0;
        cause_mux_o               = '0;
        tval_mux_o                = '0;
        resync_timer_rst_o        = '0;
        qual_status_o             = '0;
        if (rst_ni) begin
            valid_o                   = valid;
            packet_format_o           = format;
            packet_f_sync_subformat_o = subformat;
            thaddr_o                  = thaddr;
            cause_mux_o               = cause_mux;
            tval_mux_o                = tval_mux;
            resync_timer_rst_o        = resync_rst;
            qual_status_o             = qual_status;
        end
    end

endmodule

// File: tb/tb_trdb_priority.sv
// tb_trdb_priority: directed and randomized checks of trdb_priority against
// a rule-table reference model.
module tb_trdb_priority;

    typedef struct packed {
        logic valid;
        logic lc_exc, lc_upd, lc_fin;
        logic tc_qual, tc_ret, tc_exc, tc_first, tc_priv, tc_ctx;
        logic tc_gt, tc_et, tc_bm_empty, tc_bm_full, tc_en, tc_dis, tc_opm;
        logic nc_exc, nc_priv, nc_ctx, nc_bm_empty, nc_qual, nc_ret;
    } stim_t;

    // {valid, format, subformat, thaddr, cause, tval, resync_rst, qual}
    typedef logic [10:0] resp_t;

    logic  clk;
    logic  rst_n;
    stim_t s;

    logic       valid_o, thaddr_o, cause_mux_o, tval_mux_o, resync_timer_rst_o;
    logic [1:0] packet_format_o, packet_f_sync_subformat_o, qual_status_o;

    int checks = 0;
    int errors = 0;

    trdb_priority dut (
        .clk_i                     (clk),
        .rst_ni                    (rst_n),
        .valid_i                   (s.valid),
        .lc_exception_i            (s.lc_exc),
        .lc_updiscon_i             (s.lc_upd),
        .lc_final_qualified_i      (s.lc_fin),
        .tc_qualified_i            (s.tc_qual),
        .tc_retired_i              (s.tc_ret),
        .tc_exception_i            (s.tc_exc),
        .tc_first_qualified_i      (s.tc_first),
        .tc_privchange_i           (s.tc_priv),
        .tc_context_change_i       (s.tc_ctx),
        .tc_gt_max_resync_i        (s.tc_gt),
        .tc_et_max_resync_i        (s.tc_et),
        .tc_branch_map_empty_i     (s.tc_bm_empty),
        .tc_branch_map_full_i      (s.tc_bm_full),
        .tc_enc_enabled_i          (s.tc_en),
        .tc_enc_disabled_i         (s.tc_dis),
        .tc_opmode_change_i        (s.tc_opm),
        .nc_exception_i            (s.nc_exc),
        .nc_privchange_i           (s.nc_priv),
        .nc_context_change_i       (s.nc_ctx),
        .nc_branch_map_empty_i     (s.nc_bm_empty),
        .nc_qualified_i            (s.nc_qual),
        .nc_retired_i              (s.nc_ret),
        .valid_o                   (valid_o),
        .packet_format_o           (packet_format_o),
        .packet_f_sync_subformat_o (packet_f_sync_subformat_o),
        .thaddr_o                  (thaddr_o),
        .cause_mux_o               (cause_mux_o),
        .tval_mux_o                (tval_mux_o),
        .resync_timer_rst_o        (resync_timer_rst_o),
        .qual_status_o             (qual_status_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic resp_t pack_resp(input int v, input int fmt, input int sf,
                                        input int th, input int cm, input int rr,
                                        input int qs);
        resp_t r;
        r = {1'(v), 2'(fmt), 2'(sf), 1'(th), 1'(cm), 1'(cm), 1'(rr), 2'(qs)};
        return r;
    endfunction

    // Reference: evaluate every rule's trigger, take the first that fires.
    function automatic resp_t model(input stim_t x, input logic rst);
        bit hit [1:8];
        int rule;
        int f12;
        if (!rst || !x.valid) return '0;
        f12 = x.tc_bm_empty ? 2 : 1;
        hit[1] = x.tc_en || x.tc_dis || x.tc_opm;
        hit[2] = !x.tc_qual && x.lc_fin;
        hit[3] = x.tc_qual && x.tc_ret && x.lc_exc;
        hit[4] = x.tc_qual && x.tc_ret &&
                 (x.tc_first || x.tc_priv || x.tc_ctx || (x.tc_et && x.tc_bm_empty));
        hit[5] = x.tc_qual && x.tc_ret && x.lc_upd;
        hit[6] = x.tc_qual && x.tc_ret && x.tc_gt && !x.tc_bm_empty;
        hit[7] = x.tc_qual && x.tc_ret &&
                 (x.nc_exc || x.nc_priv || x.nc_ctx || !x.nc_qual || !x.nc_ret);
        hit[8] = x.tc_qual && x.tc_ret && x.tc_bm_full;
        rule = 0;
        for (int i = 8; i >= 1; i--) if (hit[i]) rule = i;
        case (rule)
            1: return pack_resp(1, 3, 3, 0, 0, 0, x.tc_dis ? 3 : 0);
            2: return pack_resp(1, 3, 3, 0, 0, 0, 1);
            3: return pack_resp(1, 3, 1, x.lc_upd ? 0 : 1, 1, 1, 0);
            4: return pack_resp(1, 3, 0, 0, 0, 1, 0);
            5: return pack_resp(1, f12, 0, 0, 0, 0, 0);
            6: return pack_resp(1, 1, 0, 0, 0, 1, 0);
            7: return pack_resp(1, f12, 0, 0, 0, 0, 0);
            8: return pack_resp(1, 1, 0, 0, 0, 0, 0);
            default: return '0;
        endcase
    endfunction

    function automatic resp_t observed();
        return {valid_o, packet_format_o, packet_f_sync_subformat_o, thaddr_o,
                cause_mux_o, tval_mux_o, resync_timer_rst_o, qual_status_o};
    endfunction

    task automatic check(input string tag, input resp_t exp);
        resp_t got;
        got = observed();
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b stim=%h", tag, got, exp, s);
        end
    endtask

    function automatic stim_t quiet_qr();
        stim_t q;
        q = '0;
        q.valid   = 1'b1;
        q.tc_qual = 1'b1;
        q.tc_ret  = 1'b1;
        q.nc_qual = 1'b1;
        q.nc_ret  = 1'b1;
        return q;
    endfunction

    initial begin
        stim_t t;
        // Reset with every input high, changed away from any clock edge.
        rst_n = 1'b0;
        s = '1;
        #3;
        check("reset_all_ones", '0);
        @(negedge clk);
        check("reset_negedge", '0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        #1;
        check("post_reset_p1", pack_resp(1, 3, 3, 0, 0, 0, 3));

        // First qualified -> start sync.
        t = quiet_qr(); t.tc_first = 1'b1; s = t; #1;
        check("start_sync", pack_resp(1, 3, 0, 0, 0, 1, 0));

        // Trap with/without updiscon.
        t = quiet_qr(); t.lc_exc = 1'b1; t.lc_upd = 1'b1; s = t; #1;
        check("trap_updiscon", pack_resp(1, 3, 1, 0, 1, 1, 0));
        t.lc_upd = 1'b0; s = t; #1;
        check("trap_no_updiscon", pack_resp(1, 3, 1, 1, 1, 1, 0));
        t.tc_first = 1'b1; s = t; #1;
        check("trap_beats_start", pack_resp(1, 3, 1, 1, 1, 1, 0));

        // Uninferable discontinuity vs branch map state.
        t = quiet_qr(); t.lc_upd = 1'b1; t.tc_bm_empty = 1'b1; s = t; #1;
        check("updiscon_empty", pack_resp(1, 2, 0, 0, 0, 0, 0));
        t.tc_bm_empty = 1'b0; s = t; #1;
        check("updiscon_nonempty", pack_resp(1, 1, 0, 0, 0, 0, 0));

        // Encoder disabled.
        t = '0; t.valid = 1'b1; t.tc_dis = 1'b1; s = t; #1;
        check("enc_disabled", pack_resp(1, 3, 3, 0, 0, 0, 3));
        t.tc_dis = 1'b0; t.tc_opm = 1'b1; s = t; #1;
        check("opmode_change", pack_resp(1, 3, 3, 0, 0, 0, 0));

        // Qualification ended.
        t = '0; t.valid = 1'b1; t.lc_fin = 1'b1; s = t; #1;
        check("qual_ended", pack_resp(1, 3, 3, 0, 0, 0, 1));

        // Branch map full only, then all quiet.
        t = quiet_qr(); t.tc_bm_full = 1'b1; s = t; #1;
        check("bm_full", pack_resp(1, 1, 0, 0, 0, 0, 0));
        t.tc_bm_full = 1'b0; s = t; #1;
        check("all_quiet", '0);
        t.tc_exc = 1'b1; t.nc_bm_empty = 1'b1; s = t; #1;
        check("reserved_ignored", '0);

        // Resync boundaries.
        t = quiet_qr(); t.tc_et = 1'b1; t.tc_bm_empty = 1'b1; s = t; #1;
        check("et_resync_empty", pack_resp(1, 3, 0, 0, 0, 1, 0));
        t = quiet_qr(); t.tc_gt = 1'b1; s = t; #1;
        check("gt_resync", pack_resp(1, 1, 0, 0, 0, 1, 0));
        t = quiet_qr(); t.nc_ret = 1'b0; t.tc_bm_empty = 1'b1; s = t; #1;
        check("nc_boundary_empty", pack_resp(1, 2, 0, 0, 0, 0, 0));

        // valid_i low masks everything.
        t = '1; t.valid = 1'b0; s = t; #1;
        check("valid_low", '0);

        // Randomized, with the encoder-control flags biased low so the lower
        // priority rules get exercised.
        for (int n = 0; n < 400; n++) begin
            @(posedge clk); #1;
            t = stim_t'($urandom);
            t.valid  = ($urandom_range(0, 7) != 0);
            t.tc_en  = ($urandom_range(0, 7) == 0);
            t.tc_dis = ($urandom_range(0, 7) == 0);
            t.tc_opm = ($urandom_range(0, 7) == 0);
            t.tc_qual = ($urandom_range(0, 3) != 0);
            t.tc_ret  = ($urandom_range(0, 3) != 0);
            t.nc_qual = ($urandom_range(0, 3) != 0);
            t.nc_ret  = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 19) != 0);
            s = t;
            @(negedge clk);
            check("random", model(s, rst_n));
        end
        rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
